pc_fetch_stage: RTL and testbench
=================================

Name: pc_fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the next-PC select mux.
- Owns the PC register and generates the sequential PC+4 internally.
- Applies redirects (taken branch/jump target, the mux's pc+offset path) and drives a single-outstanding-request handshake to instruction memory.
- Presents fetched {pc, instr} pairs to decode with a valid/ready handshake.

Parameters:
- XLEN, 32: address/data width.
- RESET_PC, 32'h0000_0000: PC loaded on reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- redirect_valid  in  1  1 = take redirect_target as next PC (select line of the next-PC mux)
- redirect_target  in  XLEN  branch/jump target (pc+offset)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (word aligned)
- imem_rsp_valid  in  1  instruction data valid
- imem_rsp_data  in  XLEN  instruction word
- if_valid  out  1  fetched instruction valid to decode
- if_ready  in  1  decode accepts
- if_pc  out  XLEN  PC of presented instruction
- if_instr  out  XLEN  presented instruction

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, state=IDLE, drop=0, imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0.
- Reset mid-operation abandons any in-flight request; the memory side must tolerate a lost response.
- States:
  - IDLE: one cycle after reset release -> REQ.
  - REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready -> WAIT.
  - WAIT: wait for imem_rsp_valid. The earliest response is the cycle after acceptance. On response with drop=0: latch if_pc=pc, if_instr=rsp_data -> HOLD.
  - HOLD: if_valid=1, outputs stable. On if_ready: pc <= pc+4 -> REQ.
- Fetch rate: at most one outstanding request; minimum 3 cycles per instruction (REQ, WAIT, HOLD).
- Arithmetic:
  - pc+4 is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
  - redirect_target[1:0] is forced to 2'b00.
- Redirect (highest priority, evaluated every cycle after reset):
  - REQ without ready: pc <= target. Address changes next cycle; this is the only permitted address change while req_valid=1.
  - REQ with ready same cycle: request is accepted. pc <= target, drop <= 1 -> WAIT.
  - WAIT: pc <= target, drop <= 1. Remain in WAIT.
  - HOLD: if_valid deasserts next cycle (even if if_ready=1 that cycle, the handshake completes but pc <= target, not pc+4) -> REQ.
  - IDLE: pc <= target.
- Dropped response: in WAIT with drop=1 and imem_rsp_valid, discard data, clear drop -> REQ with the redirected pc.
- Redirect on the same cycle as a dropped response: pc <= new target, drop=0 -> REQ.
- Back-to-back redirects: last one wins; at most one pending drop, since there is a single outstanding request.
- if_pc/if_instr change only on the WAIT->HOLD transition.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt (32) and perf_flush_cnt (32), both reset to 0, wrapping.
  - perf_fetch_cnt increments on each if_valid&&if_ready.
  - perf_flush_cnt increments on each redirect that drops a request or kills a HOLD instruction.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, RESET_PC=0, memory ready always, 1-cycle response, if_ready=1 -> req addrs 0x0,0x4,0x8; if_pc matches; one instruction every 3 cycles.
- Redirect target 0x103 asserted while in WAIT for addr 0x8 -> response for 0x8 discarded (if_valid stays 0); next req addr 0x100; next if_pc=0x100.
- if_ready=0 for 5 cycles in HOLD with if_pc=0x4 -> if_valid/if_pc/if_instr stable; no new request until if_ready=1; next req 0x8.
- RESET_PC=32'hFFFF_FFFC -> second request address 0x0.
- rst_n pulsed low during WAIT -> outputs return to reset values immediately; fetch restarts at RESET_PC.
- With FETCH_PERF_CNT_EN defined, 3 fetches plus 1 redirect in WAIT -> perf_fetch_cnt=3, perf_flush_cnt=1.

Source files
------------

// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - PC register and single-outstanding instruction fetch with redirect/drop.
// Optional FETCH_PERF_CNT_EN adds fetch/flush performance counters.
module pc_fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] tgt;

  assign tgt = redirect_target & {{(XLEN-2){1'b1}}, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_valid) pc_d = tgt;
      end
      S_REQ: begin
        if (redirect_valid) pc_d = tgt;
        if (imem_req_ready) begin
          state_d = S_WAIT;
          drop_d  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          // A redirect arriving with the response kills it just like a pending drop.
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
            if (redirect_valid) pc_d = tgt;
          end else begin
            if_pc_d    = pc_q;
            if_instr_d = imem_rsp_data;
            state_d    = S_HOLD;
          end
        end else if (redirect_valid) begin
          pc_d   = tgt;
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = tgt;
          state_d = S_REQ;
        end else if (if_ready) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign if_valid       = (state_q == S_HOLD);
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_flush_q;
  logic        flush_inc;

  // Only the first redirect of a given request/instruction counts as a flush.
  assign flush_inc = redirect_valid &&
                     ((state_q == S_HOLD) ||
                      (state_q == S_REQ && imem_req_ready) ||
                      (state_q == S_WAIT && !drop_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (if_valid && if_ready) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (flush_inc)            perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb/tb_pc_fetch_stage.sv - randomized bench with behavioural fetch model for pc_fetch_stage.
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  logic        rst2_n = 1'b0;
  logic        rsp2_valid = 1'b0;
  logic        req2_valid;
  logic [31:0] req2_addr;
  logic        if2_valid;
  logic [31:0] if2_pc, if2_instr;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt;
  logic [31:0] perf2_fetch, perf2_flush;
`endif

  always #5 clk = ~clk;

  pc_fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  pc_fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst2_n),
    .redirect_valid(1'b0), .redirect_target(32'h0),
    .imem_req_valid(req2_valid), .imem_req_ready(1'b1),
    .imem_req_addr(req2_addr),
    .imem_rsp_valid(rsp2_valid), .imem_rsp_data(32'h1234_5678),
    .if_valid(if2_valid), .if_ready(1'b1), .if_pc(if2_pc), .if_instr(if2_instr)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf2_fetch), .perf_flush_cnt(perf2_flush)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Behavioural model: phase 0 idle, 1 requesting, 2 awaiting data, 3 presenting.
  int          m_phase;
  logic [31:0] m_pc, m_ifpc, m_ifinstr, m_fetch, m_flush;
  logic        m_stale;

  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;

  int k_rdy, k_dly_min, k_dly_max, k_ifr, k_rv;
  logic        ov_rv, ov_ifr0;
  logic [31:0] ov_rt;

  logic [31:0] req_log[$];
  logic [31:0] ho_pc[$];
  int          ho_cyc[$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic pick(input int k);
    return int'($urandom_range(0, 99)) < k;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_pc = 32'h0; m_stale = 1'b0;
    m_ifpc = '0; m_ifinstr = '0; m_fetch = '0; m_flush = '0;
    mem_pend = 1'b0; mem_cnt = 0; mem_addr = '0;
    req_log.delete(); ho_pc.delete(); ho_cyc.delete();
  endtask

  task automatic compare();
    chk("req_valid", 32'(imem_req_valid), 32'(m_phase == 1));
    chk("req_addr", imem_req_addr, m_pc);
    chk("if_valid", 32'(if_valid), 32'(m_phase == 3));
    chk("if_pc", if_pc, m_ifpc);
    chk("if_instr", if_instr, m_ifinstr);
    if (if_valid) chk("instr_matches_pc", if_instr, memfn(if_pc));
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, m_fetch);
    chk("perf_flush", perf_flush_cnt, m_flush);
`endif
  endtask

  task automatic edge_update();
    logic [31:0] tgt, old_pc;
    logic        acc;
    if (!rst_n) return;
    tgt    = redirect_target & 32'hFFFF_FFFC;
    old_pc = m_pc;
    acc    = (m_phase == 1) && imem_req_ready;
    if (m_phase == 3 && if_ready) m_fetch++;
    case (m_phase)
      0: begin m_phase = 1; if (redirect_valid) m_pc = tgt; end
      1: begin
        if (redirect_valid) m_pc = tgt;
        if (imem_req_ready) begin
          m_phase = 2;
          m_stale = redirect_valid;
          if (redirect_valid) m_flush++;
        end
      end
      2: begin
        if (redirect_valid && !m_stale) m_flush++;
        if (imem_rsp_valid) begin
          if (m_stale || redirect_valid) begin
            m_stale = 1'b0; m_phase = 1;
            if (redirect_valid) m_pc = tgt;
          end else begin
            m_ifpc = m_pc; m_ifinstr = imem_rsp_data; m_phase = 3;
          end
        end else if (redirect_valid) begin
          m_pc = tgt; m_stale = 1'b1;
        end
      end
      default: begin
        if (redirect_valid) begin m_pc = tgt; m_flush++; m_phase = 1; end
        else if (if_ready) begin m_pc = m_pc + 32'd4; m_phase = 1; end
      end
    endcase
    if (acc) begin
      mem_pend = 1'b1; mem_addr = old_pc;
      mem_cnt  = int'($urandom_range(k_dly_min, k_dly_max));
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    if (ov_ifr0) begin
      chk("hold_valid", 32'(if_valid), 32'h1);
      chk("hold_pc", if_pc, 32'h4);
      chk("hold_instr", if_instr, memfn(32'h4));
      chk("hold_noreq", 32'(imem_req_valid), 32'h0);
    end
    redirect_valid  = ov_rv || pick(k_rv);
    redirect_target = ov_rv ? ov_rt :
                      (pick(25) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom_range(0, 4095));
    imem_req_ready  = pick(k_rdy);
    if_ready        = ov_ifr0 ? 1'b0 : pick(k_ifr);
    ov_rv = 1'b0; ov_ifr0 = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memfn(mem_addr);
        mem_pend       = 1'b0;
      end
    end
    if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
    if (if_valid && if_ready) begin ho_pc.push_back(if_pc); ho_cyc.push_back(cyc); end
    @(posedge clk);
    edge_update();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    chk("rst_perf_flush", perf_flush_cnt, 32'h0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    edge_update();
  endtask

  task automatic run_wrap();
    logic        was;
    logic [31:0] q2[$];
    was = 1'b0;
    repeat (2) @(negedge clk);
    chk("wrap_rst_addr", req2_addr, 32'hFFFF_FFFC);
    rst2_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rsp2_valid = was;
      was = req2_valid;
      if (req2_valid) q2.push_back(req2_addr);
    end
    chk("wrap_req_count", 32'(q2.size() >= 2), 32'h1);
    if (q2.size() >= 2) begin
      chk("wrap_req0", q2[0], 32'hFFFF_FFFC);
      chk("wrap_req1", q2[1], 32'h0000_0000);
    end
  endtask

  initial begin
    logic redir_done;
    int   hold_n;
    ov_rv = 1'b0; ov_ifr0 = 1'b0; ov_rt = '0;
    k_rdy = 100; k_dly_min = 1; k_dly_max = 1; k_ifr = 100; k_rv = 0;
    model_reset();

    run_wrap();

    // Sequential fetch, then a redirect to 0x103 while waiting on 0x8.
    do_reset();
    redir_done = 1'b0;
    for (int i = 0; i < 80 && ho_pc.size() < 3; i++) begin
      if (req_log.size() >= 2) begin k_dly_min = 2; k_dly_max = 2; end
      if (!redir_done && req_log.size() == 3 && m_phase == 2) begin
        ov_rv = 1'b1; ov_rt = 32'h0000_0103; redir_done = 1'b1;
      end
      step();
    end
    chk("p1_handoffs", 32'(ho_pc.size()), 32'd3);
    chk("p1_reqs", 32'(req_log.size()), 32'd4);
    if (req_log.size() >= 4) begin
      chk("p1_req0", req_log[0], 32'h0);
      chk("p1_req1", req_log[1], 32'h4);
      chk("p1_req2", req_log[2], 32'h8);
      chk("p1_req3", req_log[3], 32'h100);
    end
    if (ho_pc.size() >= 3) begin
      chk("p1_ho0", ho_pc[0], 32'h0);
      chk("p1_ho1", ho_pc[1], 32'h4);
      chk("p1_ho2", ho_pc[2], 32'h100);
      chk("p1_rate", 32'(ho_cyc[1] - ho_cyc[0]), 32'd3);
    end
`ifdef FETCH_PERF_CNT_EN
    #1;
    chk("p1_perf_fetch", perf_fetch_cnt, 32'd3);
    chk("p1_perf_flush", perf_flush_cnt, 32'd1);
`endif

    // Decode stalls 5 cycles while 0x4 is presented.
    k_dly_min = 1; k_dly_max = 1;
    do_reset();
    hold_n = 0;
    for (int i = 0; i < 80 && req_log.size() < 3; i++) begin
      if (m_phase == 3 && m_ifpc == 32'h4 && hold_n < 5) begin ov_ifr0 = 1'b1; hold_n++; end
      step();
    end
    chk("p3_hold_cycles", 32'(hold_n), 32'd5);
    chk("p3_reqs", 32'(req_log.size()), 32'd3);
    if (req_log.size() >= 3) chk("p3_req2", req_log[2], 32'h8);

    // Reset pulse while a request is outstanding.
    k_dly_min = 3; k_dly_max = 3;
    for (int i = 0; i < 20 && m_phase != 2; i++) step();
    chk("p4_in_wait", 32'(m_phase), 32'd2);
    do_reset();
    k_dly_min = 1; k_dly_max = 1;
    for (int i = 0; i < 20 && req_log.size() < 1; i++) step();
    chk("p4_restart_req", 32'(req_log.size()), 32'd1);
    if (req_log.size() >= 1) chk("p4_restart_addr", req_log[0], 32'h0);

    // Randomized traffic, knobs reshuffled every 200 cycles.
    for (int blk = 0; blk < 15; blk++) begin
      k_rdy = int'($urandom_range(30, 100));
      k_dly_min = 1; k_dly_max = int'($urandom_range(1, 4));
      k_ifr = int'($urandom_range(30, 100));
      k_rv  = int'($urandom_range(0, 15));
      for (int i = 0; i < 200; i++) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
